trail_emitter: RTL

//  Synthesisable particle-trail pool driving trail_x/trail_y/trail_life of vga_screen_pic.

---
 rtl/trail_emitter_if.sv | 26 ++
 rtl/trail_emitter.sv | 135 +++++++++++++
 2 files changed

// File: rtl/trail_emitter_if.sv
// Bundle between game logic and the trail pool.
// Frame control flows in; the slot table flows out to the renderer.
interface trail_emitter_if #(
   parameter int N_SLOTS = 41,
   parameter int LIFE_W  = 4
);
   logic                              frame_tick;
   logic                              enable;
   logic                              clear;
   logic [8:0]                        player_y;
   logic [N_SLOTS-1:0][9:0]           trail_x;
   logic [N_SLOTS-1:0][8:0]           trail_y;
   logic [N_SLOTS-1:0][LIFE_W-1:0]    trail_life;
   logic                              busy;
   logic                              overrun;

   modport master (
      output frame_tick, enable, clear, player_y,
      input  trail_x, trail_y, trail_life, busy, overrun
   );

   modport slave (
      input  frame_tick, enable, clear, player_y,
      output trail_x, trail_y, trail_life, busy, overrun
   );
endinterface

// File: rtl/trail_emitter.sv
// Particle-trail pool: per-frame burst spawn into a ring of slots,
// followed by a single parallel ageing/drift pass.
module trail_emitter #(
   parameter int N_SLOTS         = 41,
   parameter int SPAWN_PER_FRAME = 5,
   parameter int LIFE_MAX        = 10,
   parameter int LIFE_W          = 4,
   parameter int PLAYER_X        = 200,
   parameter int PLAYER_SIZE     = 40,
   parameter int X_OFFSET        = 5,
   parameter int SPREAD          = 8,
   parameter int DRIFT           = 0,
   parameter int Y_MAX           = 479
) (
   input logic              clk,
   input logic              rst_n,
   trail_emitter_if.slave   bus
);

   localparam int PW = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1;
   localparam int IW = (SPAWN_PER_FRAME > 1) ? $clog2(SPAWN_PER_FRAME) : 1;

   localparam logic [9:0]        SPAWN_X = 10'(PLAYER_X - X_OFFSET);
   localparam logic [9:0]        DRIFT_X = 10'(DRIFT);
   localparam logic [LIFE_W-1:0] LIFE_I  = LIFE_W'(LIFE_MAX);
   localparam logic signed [15:0] YMAX_S = 16'(Y_MAX);

   typedef enum logic [1:0] {
      IDLE,
      SPAWN,
      DECAY
   } state_t;

   state_t           state;
   state_t           state_nx;
   logic [PW-1:0]    wr_ptr;
   logic [IW-1:0]    idx;
   logic [8:0]       py_q;
   logic signed [15:0] ysum;
   logic [8:0]       spawn_y;
   logic             last_spawn;

   assign last_spawn = (idx == IW'(SPAWN_PER_FRAME - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      if (bus.clear) begin
         state_nx = IDLE;
      end else begin
         unique case (state)
            IDLE:
               if (bus.frame_tick)
                  state_nx = bus.enable ? SPAWN : DECAY;
            SPAWN:
               if (last_spawn)
                  state_nx = DECAY;
            DECAY:
               state_nx = IDLE;
            default:
               state_nx = IDLE;
         endcase
      end
   end

   // Burst fan is centred on the sprite; the sum may go negative.
   always_comb begin
      ysum = 16'(int'(py_q) + PLAYER_SIZE / 2
                 + (int'(idx) - SPAWN_PER_FRAME / 2) * SPREAD);
      if (ysum < 0)
         spawn_y = '0;
      else if (ysum > YMAX_S)
         spawn_y = 9'(Y_MAX);
      else
         spawn_y = ysum[8:0];
   end

   assign bus.busy = (state != IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.trail_x    <= '0;
         bus.trail_y    <= '0;
         bus.trail_life <= '0;
         bus.overrun    <= 1'b0;
         wr_ptr         <= '0;
         idx            <= '0;
         py_q           <= '0;
      end else if (bus.clear) begin
         bus.trail_x    <= '0;
         bus.trail_y    <= '0;
         bus.trail_life <= '0;
         bus.overrun    <= 1'b0;
         wr_ptr         <= '0;
         idx            <= '0;
      end else begin
         if (bus.frame_tick && state != IDLE)
            bus.overrun <= 1'b1;
         unique case (state)
            IDLE: begin
               if (bus.frame_tick) begin
                  py_q <= bus.player_y;
                  idx  <= '0;
               end
            end
            SPAWN: begin
               bus.trail_x[wr_ptr]    <= SPAWN_X;
               bus.trail_y[wr_ptr]    <= spawn_y;
               bus.trail_life[wr_ptr] <= LIFE_I;
               wr_ptr <= (wr_ptr == PW'(N_SLOTS - 1)) ?
                         '0 : wr_ptr + 1'b1;
               idx    <= idx + 1'b1;
            end
            DECAY: begin
               for (int s = 0; s < N_SLOTS; s++) begin
                  if (bus.trail_life[s] != '0) begin
                     if (bus.trail_x[s] >= DRIFT_X) begin
                        bus.trail_x[s]    <= bus.trail_x[s] - DRIFT_X;
                        bus.trail_life[s] <= bus.trail_life[s] - 1'b1;
                     end else begin
                        bus.trail_life[s] <= '0;
                     end
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule
